// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op encodings, flag bit positions
// and the arbiter state enum.
package alu_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned FLAG_W = 5;
   localparam int unsigned CNT_W  = 16;

   localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB = 4'b1000;
   localparam logic [OP_W-1:0] OP_AND = 4'b0001;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0010;
   localparam logic [OP_W-1:0] OP_XOR = 4'b0011;

   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_L = 1;
   localparam int unsigned FLAG_F = 2;
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the two-port ALU arbiter.
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
);
   logic              req0_valid;
   logic              req0_ready;
   logic [WIDTH-1:0]  req0_a;
   logic [WIDTH-1:0]  req0_b;
   logic [OP_W-1:0]   req0_op;
   logic              req0_setflags;

   logic              req1_valid;
   logic              req1_ready;
   logic [WIDTH-1:0]  req1_a;
   logic [WIDTH-1:0]  req1_b;
   logic [OP_W-1:0]   req1_op;
   logic              req1_setflags;

   logic              resp0_valid;
   logic              resp1_valid;
   logic [WIDTH-1:0]  resp_data;
   logic [FLAG_W-1:0] resp_flags;

   logic [WIDTH-1:0]  alu_reg1;
   logic [WIDTH-1:0]  alu_reg2;
   logic [OP_W-1:0]   alu_inst;
   logic              alu_flagWrite;
   logic [WIDTH-1:0]  alu_result;
   logic [FLAG_W-1:0] alu_flags;

   logic [CNT_W-1:0]  ops_done;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op, req0_setflags,
      input  req1_valid, req1_a, req1_b, req1_op, req1_setflags,
      input  alu_result, alu_flags,
      output req0_ready, req1_ready, resp0_valid, resp1_valid,
      output resp_data, resp_flags, alu_reg1, alu_reg2, alu_inst,
      output alu_flagWrite, ops_done
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op, req0_setflags,
      output req1_valid, req1_a, req1_b, req1_op, req1_setflags,
      output alu_result, alu_flags,
      input  req0_ready, req1_ready, resp0_valid, resp1_valid,
      input  resp_data, resp_flags, alu_reg1, alu_reg2, alu_inst,
      input  alu_flagWrite, ops_done
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the requester
// not granted last wins (last=1 means requester 1 was granted last).
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant    = 2'b00;
      grant[0] = req[0] & (~req[1] | last);
      grant[1] = req[1] & (~req[0] | ~last);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: accept, execute for one
// cycle, then return the result to the owner while accepting the next op.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              owner_q, owner_d;
   logic              flag_write_q, flag_write_d;
   logic [WIDTH-1:0]  reg1_q, reg1_d;
   logic [WIDTH-1:0]  reg2_q, reg2_d;
   logic [OP_W-1:0]   inst_q, inst_d;
   logic              resp0_valid_q, resp0_valid_d;
   logic              resp1_valid_q, resp1_valid_d;
   logic [WIDTH-1:0]  resp_data_q, resp_data_d;
   logic [FLAG_W-1:0] resp_flags_q, resp_flags_d;
   logic [CNT_W-1:0]  ops_done_q, ops_done_d;

   logic [1:0] grant_c;
   logic       window_c;
   logic       accept_c;

   rr_arb2 u_rr_arb2 (
      .req   ({bus.req1_valid, bus.req0_valid}),
      .last  (last_q),
      .grant (grant_c)
   );

   // Acceptance window: IDLE or RESP, never while reset is held.
   assign window_c       = ((state_q == IDLE) || (state_q == RESP)) && !rst;
   assign accept_c       = window_c && (grant_c != 2'b00);
   assign bus.req0_ready = window_c & grant_c[0];
   assign bus.req1_ready = window_c & grant_c[1];

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      owner_d       = owner_q;
      flag_write_d  = 1'b0;
      reg1_d        = reg1_q;
      reg2_d        = reg2_q;
      inst_d        = inst_q;
      resp0_valid_d = 1'b0;
      resp1_valid_d = 1'b0;
      resp_data_d   = resp_data_q;
      resp_flags_d  = resp_flags_q;
      ops_done_d    = ops_done_q;

      case (state_q)
         IDLE, RESP: begin
            if (state_q == RESP) ops_done_d = ops_done_q + CNT_W'(1);
            if (accept_c) begin
               reg1_d       = grant_c[1] ? bus.req1_a : bus.req0_a;
               reg2_d       = grant_c[1] ? bus.req1_b : bus.req0_b;
               inst_d       = grant_c[1] ? bus.req1_op : bus.req0_op;
               flag_write_d = grant_c[1] ? bus.req1_setflags : bus.req0_setflags;
               owner_d      = grant_c[1];
               last_d       = grant_c[1];
               state_d      = EXEC;
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            // ALU flags were written on the falling edge inside EXEC.
            resp_data_d   = bus.alu_result;
            resp_flags_d  = bus.alu_flags;
            resp0_valid_d = ~owner_q;
            resp1_valid_d = owner_q;
            state_d       = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         last_q        <= 1'b1;
         owner_q       <= 1'b0;
         flag_write_q  <= 1'b0;
         reg1_q        <= '0;
         reg2_q        <= '0;
         inst_q        <= '0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         resp_data_q   <= '0;
         resp_flags_q  <= '0;
         ops_done_q    <= '0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         owner_q       <= owner_d;
         flag_write_q  <= flag_write_d;
         reg1_q        <= reg1_d;
         reg2_q        <= reg2_d;
         inst_q        <= inst_d;
         resp0_valid_q <= resp0_valid_d;
         resp1_valid_q <= resp1_valid_d;
         resp_data_q   <= resp_data_d;
         resp_flags_q  <= resp_flags_d;
         ops_done_q    <= ops_done_d;
      end
   end

   assign bus.alu_reg1      = reg1_q;
   assign bus.alu_reg2      = reg2_q;
   assign bus.alu_inst      = inst_q;
   assign bus.alu_flagWrite = flag_write_q;
   assign bus.resp0_valid   = resp0_valid_q;
   assign bus.resp1_valid   = resp1_valid_q;
   assign bus.resp_data     = resp_data_q;
   assign bus.resp_flags    = resp_flags_q;
   assign bus.ops_done      = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the external ALU, predicts grants and
// responses into a scoreboard, and compares each response strobe.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int unsigned W = 16;

   logic clk;
   logic rst;

   alu_arbiter_if #(.WIDTH(W)) bus ();

   alu_arbiter #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int         owner;
      logic [15:0] data;
      logic [4:0]  flags;
   } exp_t;

   exp_t       sb[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic       m_last;
   bit         m_exec;
   logic [4:0] m_flags;

   // External ALU: {flags, result}; flags C,L,F,Z,N at bits 0..4.
   function automatic logic [20:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
      logic [16:0] s;
      logic [15:0] r;
      logic [4:0]  f;
      f = 5'b0;
      r = 16'h0;
      case (op[2:0])
         3'd0: begin
            s = op[3] ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
            r = s[15:0];
            f[FLAG_C] = s[16];
            f[FLAG_F] = op[3] ? ((a[15] != b[15]) && (r[15] != a[15]))
                              : ((a[15] == b[15]) && (r[15] != a[15]));
         end
         3'd1: r = a & b;
         3'd2: r = a | b;
         3'd3: r = a ^ b;
         default: r = 16'h0;
      endcase
      f[FLAG_L] = (a < b);
      f[FLAG_Z] = (r == 16'h0);
      f[FLAG_N] = r[15];
      return {f, r};
   endfunction

   logic [20:0] alu_out;
   logic [4:0]  alu_flags_r;
   assign alu_out        = alu_calc(bus.alu_reg1, bus.alu_reg2, bus.alu_inst);
   assign bus.alu_result = alu_out[15:0];
   assign bus.alu_flags  = alu_flags_r;

   always @(negedge clk or posedge rst) begin
      if (rst) alu_flags_r <= 5'b0;
      else if (bus.alu_flagWrite) alu_flags_r <= alu_out[20:16];
   end

   // Response monitor: every strobe must match the oldest predicted op.
   always @(posedge clk) begin : monitor
      exp_t       e;
      logic [1:0] want;
      #1;
      if (bus.resp0_valid || bus.resp1_valid) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL resp_unexpected: resp0_valid=%b resp1_valid=%b, no op outstanding",
                     bus.resp0_valid, bus.resp1_valid);
         end else begin
            e    = sb.pop_front();
            want = (e.owner == 1) ? 2'b10 : 2'b01;
            if ({bus.resp1_valid, bus.resp0_valid} !== want || bus.resp_data !== e.data ||
                bus.resp_flags !== e.flags) begin
               miscompares++;
               $display("FAIL resp: got valid=%b data=%h flags=%b expected valid=%b data=%h flags=%b",
                        {bus.resp1_valid, bus.resp0_valid}, bus.resp_data, bus.resp_flags,
                        want, e.data, e.flags);
            end
         end
      end
   end

   task automatic model_reset();
      sb.delete();
      m_last  = 1'b1;
      m_exec  = 1'b0;
      m_flags = 5'b0;
   endtask

   task automatic drive(input int n, input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic sf);
      if (n == 0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
         bus.req0_op = op; bus.req0_setflags = sf;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
         bus.req1_op = op; bus.req1_setflags = sf;
      end
   endtask

   task automatic idle_inputs();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   // One clock from a falling edge: predict grant, push expected result.
   task automatic cycle();
      logic        g0, g1, sf;
      logic [20:0] r;
      logic [15:0] a, b;
      logic [3:0]  op;
      #1;
      g0 = 1'b0;
      g1 = 1'b0;
      if (!m_exec && !rst) begin
         if (bus.req0_valid && (!bus.req1_valid || m_last)) g0 = 1'b1;
         else if (bus.req1_valid) g1 = 1'b1;
      end
      vectors++;
      if (bus.req0_ready !== g0 || bus.req1_ready !== g1) begin
         miscompares++;
         $display("FAIL ready: got r0=%b r1=%b expected r0=%b r1=%b at %0t",
                  bus.req0_ready, bus.req1_ready, g0, g1, $time);
      end
      m_exec = 1'b0;
      if (g0 || g1) begin
         a  = g1 ? bus.req1_a : bus.req0_a;
         b  = g1 ? bus.req1_b : bus.req0_b;
         op = g1 ? bus.req1_op : bus.req0_op;
         sf = g1 ? bus.req1_setflags : bus.req0_setflags;
         r  = alu_calc(a, b, op);
         if (sf) m_flags = r[20:16];
         sb.push_back('{g1 ? 1 : 0, r[15:0], m_flags});
         m_last = g1;
         m_exec = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      drive(0, 1'b1, 16'h1111, 16'h2222, OP_ADD, 1'b1);
      drive(1, 1'b1, 16'h3333, 16'h4444, OP_SUB, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready: got r0=%b r1=%b expected 0 0", bus.req0_ready, bus.req1_ready);
      end
      vectors++;
      if ({bus.resp0_valid, bus.resp1_valid, bus.alu_flagWrite} !== 3'b000 ||
          bus.alu_reg1 !== 16'h0 || bus.alu_reg2 !== 16'h0 || bus.alu_inst !== 4'h0 ||
          bus.resp_data !== 16'h0 || bus.resp_flags !== 5'h0 || bus.ops_done !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b fw=%b r1=%h r2=%h inst=%h data=%h flags=%b ops=%h expected all 0",
                  {bus.resp1_valid, bus.resp0_valid}, bus.alu_flagWrite, bus.alu_reg1, bus.alu_reg2,
                  bus.alu_inst, bus.resp_data, bus.resp_flags, bus.ops_done);
      end
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_add();
      drive(0, 1'b1, 16'h0003, 16'h0004, OP_ADD, 1'b1);
      cycle();
      idle_inputs();
      vectors++;
      if (bus.alu_flagWrite !== 1'b1 || bus.alu_reg1 !== 16'h0003 || bus.alu_reg2 !== 16'h0004 ||
          bus.alu_inst !== OP_ADD) begin
         miscompares++;
         $display("FAIL add_exec: got fw=%b r1=%h r2=%h inst=%h expected 1 0003 0004 0",
                  bus.alu_flagWrite, bus.alu_reg1, bus.alu_reg2, bus.alu_inst);
      end
      cycle();
      vectors++;
      if (bus.resp0_valid !== 1'b1 || bus.resp1_valid !== 1'b0 || bus.resp_data !== 16'h0007 ||
          bus.resp_flags[FLAG_Z] !== 1'b0 || bus.resp_flags[FLAG_C] !== 1'b0 ||
          bus.resp_flags[FLAG_N] !== 1'b0) begin
         miscompares++;
         $display("FAIL add_resp: got v0=%b v1=%b data=%h flags=%b expected 1 0 0007 Z=C=N=0",
                  bus.resp0_valid, bus.resp1_valid, bus.resp_data, bus.resp_flags);
      end
      cycle();
      vectors++;
      if (bus.ops_done !== 16'd1 || bus.resp0_valid !== 1'b0 || bus.resp_data !== 16'h0007) begin
         miscompares++;
         $display("FAIL add_after: got ops=%0d v0=%b data=%h expected 1 0 0007",
                  bus.ops_done, bus.resp0_valid, bus.resp_data);
      end
   endtask

   task automatic test_round_robin();
      logic e0, e1;
      pulse_reset();
      drive(0, 1'b1, 16'h0005, 16'h0005, OP_SUB, 1'b1);
      drive(1, 1'b1, 16'h0005, 16'h0005, OP_SUB, 1'b1);
      for (int i = 0; i < 8; i++) begin
         #1;
         e0 = ((i % 4) == 0);
         e1 = ((i % 4) == 2);
         vectors++;
         if (bus.req0_ready !== e0 || bus.req1_ready !== e1) begin
            miscompares++;
            $display("FAIL rr_grant[%0d]: got r0=%b r1=%b expected r0=%b r1=%b",
                     i, bus.req0_ready, bus.req1_ready, e0, e1);
         end
         cycle();
      end
      idle_inputs();
      repeat (3) cycle();
      vectors++;
      if (bus.ops_done !== 16'd4 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL rr_done: got ops=%0d pending=%0d expected 4 0", bus.ops_done, sb.size());
      end
   endtask

   task automatic test_flags_hold();
      logic [4:0] f1;
      drive(1, 1'b1, 16'hFFFF, 16'h0001, OP_ADD, 1'b1);
      cycle();
      idle_inputs();
      cycle();
      vectors++;
      if (bus.resp1_valid !== 1'b1 || bus.resp0_valid !== 1'b0 || bus.resp_data !== 16'h0 ||
          bus.resp_flags[FLAG_C] !== 1'b1 || bus.resp_flags[FLAG_Z] !== 1'b1) begin
         miscompares++;
         $display("FAIL carry_resp: got v1=%b v0=%b data=%h flags=%b expected 1 0 0000 C=1 Z=1",
                  bus.resp1_valid, bus.resp0_valid, bus.resp_data, bus.resp_flags);
      end
      f1 = bus.resp_flags;
      drive(1, 1'b1, 16'h00F0, 16'h0F00, OP_AND, 1'b0);
      cycle();
      idle_inputs();
      vectors++;
      if (bus.alu_flagWrite !== 1'b0 || bus.alu_inst !== OP_AND) begin
         miscompares++;
         $display("FAIL noflag_exec: got fw=%b inst=%h expected 0 1", bus.alu_flagWrite, bus.alu_inst);
      end
      cycle();
      vectors++;
      if (bus.resp1_valid !== 1'b1 || bus.resp_data !== 16'h0 || bus.resp_flags !== f1) begin
         miscompares++;
         $display("FAIL noflag_resp: got v1=%b data=%h flags=%b expected 1 0000 %b",
                  bus.resp1_valid, bus.resp_data, bus.resp_flags, f1);
      end
      cycle();
   endtask

   task automatic test_reset_mid_exec();
      drive(0, 1'b1, 16'h0011, 16'h0022, OP_XOR, 1'b1);
      cycle();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      #1;
      vectors++;
      if ({bus.resp0_valid, bus.resp1_valid, bus.alu_flagWrite} !== 3'b000 ||
          bus.alu_reg1 !== 16'h0 || bus.alu_inst !== 4'h0 || bus.resp_data !== 16'h0 ||
          bus.resp_flags !== 5'h0 || bus.ops_done !== 16'h0) begin
         miscompares++;
         $display("FAIL midexec_reset: got v=%b fw=%b r1=%h inst=%h data=%h flags=%b ops=%h expected all 0",
                  {bus.resp1_valid, bus.resp0_valid}, bus.alu_flagWrite, bus.alu_reg1,
                  bus.alu_inst, bus.resp_data, bus.resp_flags, bus.ops_done);
      end
      drive(0, 1'b1, 16'h0100, 16'h0023, OP_ADD, 1'b1);
      drive(1, 1'b1, 16'h0200, 16'h0001, OP_OR, 1'b1);
      repeat (2) cycle();
      rst = 1'b0;
      #1;
      vectors++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_grant: got r0=%b r1=%b expected 1 0", bus.req0_ready, bus.req1_ready);
      end
      cycle();
      idle_inputs();
      repeat (3) cycle();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL post_reset_drain: got pending=%0d expected 0", sb.size());
      end
   endtask

   task automatic test_wrap_undef();
      force dut.ops_done_q = 16'hFFFF;
      @(negedge clk);
      release dut.ops_done_q;
      #1;
      vectors++;
      if (bus.ops_done !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL preload: got ops=%h expected ffff", bus.ops_done);
      end
      drive(0, 1'b1, 16'h1234, 16'h5678, 4'b0111, 1'b1);
      cycle();
      idle_inputs();
      vectors++;
      if (bus.alu_inst !== 4'b0111) begin
         miscompares++;
         $display("FAIL undef_fwd: got inst=%b expected 0111", bus.alu_inst);
      end
      cycle();
      vectors++;
      if (bus.resp0_valid !== 1'b1 || bus.resp_data !== 16'h0) begin
         miscompares++;
         $display("FAIL undef_resp: got v0=%b data=%h expected 1 0000", bus.resp0_valid, bus.resp_data);
      end
      cycle();
      vectors++;
      if (bus.ops_done !== 16'h0) begin
         miscompares++;
         $display("FAIL wrap: got ops=%h expected 0000", bus.ops_done);
      end
   endtask

   initial begin
      rst = 1'b1;
      model_reset();
      drive(0, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
      drive(1, 1'b0, 16'h0, 16'h0, OP_ADD, 1'b0);
      test_reset();
      test_single_add();
      test_round_robin();
      test_flags_hold();
      test_reset_mid_exec();
      test_wrap_undef();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand/result width of the shared ALU.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid  input  1  (N=0,1)  requester N has an operation pending.
REQ-005 SHALL have ports reqN_ready  output  1  request accepted this cycle when valid&ready.
REQ-006 SHALL have ports reqN_a, reqN_b  input  WIDTH  operands; reqN_op  input  4  ALU instruction (bit3 = subtract, bits2:0 = operation); reqN_setflags  input  1  update flags.
REQ-007 SHALL have ports respN_valid  output  1  one-cycle result strobe to requester N.
REQ-008 SHALL have ports resp_data  output  WIDTH and resp_flags  output  5, shared by both requesters.
REQ-009 SHALL have ports alu_reg1, alu_reg2  output  WIDTH; alu_inst  output  4; alu_flagWrite  output  1, all driving the ALU.
REQ-010 SHALL have ports alu_result  input  WIDTH (combinational ALU result) and alu_flags  input  5 (ALU flag register: C,L,F,Z,N at bits 0..4).
REQ-011 SHALL have port ops_done  output  16  count of completed operations.

Function
REQ-012 SHALL implement states IDLE, EXEC, RESP.
REQ-013 SHALL accept a request only in IDLE or RESP; reqN_ready SHALL be 1 only for the granted requester in those states, 0 otherwise.
REQ-014 reqN_ready MAY depend combinationally on reqX_valid; requesters' valid SHALL NOT depend on ready.
REQ-015 With one valid requester, grant it; with both valid, grant the one not granted last (round-robin); last-grant bit updates only on acceptance.
REQ-016 On acceptance: latch a, b, op, setflags and grantee into alu_reg1, alu_reg2, alu_inst, flag-enable and owner registers; next state EXEC.
REQ-017 In IDLE/RESP with no acceptance: next state IDLE; alu_reg1/2/inst hold last values.
REQ-018 alu_flagWrite SHALL be 1 only in EXEC and only if latched setflags=1 (ALU samples flags on the falling edge within EXEC).
REQ-019 At the rising edge ending EXEC: resp_data <= alu_result; resp_flags <= alu_flags; next state RESP.
REQ-020 In RESP: respN_valid=1 for the owner only, exactly one cycle; resp_data/resp_flags hold until the next EXEC completes.
REQ-021 Latency: acceptance edge to respN_valid = 2 cycles; back-to-back throughput = one op per 2 cycles (accept in RESP).
REQ-022 When setflags=0, resp_flags SHALL report the ALU flag register unchanged from the prior op.
REQ-023 op codes with bits2:0 >= 4 SHALL be forwarded unchanged; the result (0) is returned normally.
REQ-024 ops_done SHALL increment by 1 on each RESP cycle, wrapping 16'hFFFF -> 0.
REQ-025 Requester valid dropping while not accepted SHALL have no effect; no request is remembered.

Reset
REQ-026 On rst assertion, asynchronously: state=IDLE, respN_valid=0, alu_flagWrite=0, alu_reg1/2=0, alu_inst=0, resp_data=0, resp_flags=0, ops_done=0, last-grant=1 (so requester 0 wins first tie).
REQ-027 Reset in EXEC or RESP SHALL discard the in-flight op; no respN_valid is produced for it.
REQ-028 reqN_ready SHALL be 0 while rst=1.

Structure
REQ-029 Shared package alu_pkg SHALL hold op encodings (ADD=4'b0000, SUB=4'b1000, AND=4'b0001, OR=4'b0010, XOR=4'b0011), flag bit indices (C=0, L=1, F=2, Z=3, N=4) and the state enum.
REQ-030 The two-way round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last; output grant[1:0]).

Verification
REQ-031 Single req0 ADD a=16'h0003 b=16'h0004 setflags=1 -> resp0_valid 2 cycles after accept, resp_data=16'h0007, flags Z=0,C=0,N=0; ops_done=1.
REQ-032 Both valid every cycle after reset, SUB 5-5 -> grants alternate 0,1,0,1; each resp_data=0, Z=1; respN_valid never to non-owner.
REQ-033 req1 ADD 16'hFFFF+16'h0001 setflags=1, then req1 AND 16'h00F0&16'h0F00 setflags=0 -> first resp_data=0, C=1, Z=1; second resp_data=0, resp_flags identical to first.
REQ-034 rst asserted mid-EXEC -> no respN_valid, all outputs at reset values immediately, next request after release granted to requester 0.
REQ-035 Preload ops_done to 16'hFFFF via 65535 ops (or force) then one op -> ops_done=0; op code 4'b0111 -> resp_data=0, response still delivered.
